// File: rtl/window_median_filter.sv
// Window median filter: captures a WINDOW_SIZE x WINDOW_SIZE window serially and returns
// the per-channel median. Define FILTER_MEAN_EN to return the per-channel truncated mean.
module window_median_filter #(
  parameter int DATA_WIDTH  = 24,
  parameter int CHANNELS    = 3,
  parameter int WINDOW_SIZE = 3
) (
  input  logic                  Control_CLK,
  input  logic                  Control_RST,
  input  logic                  Filter_EN,
  input  logic [DATA_WIDTH-1:0] Filter_PIXEL,
  output logic                  Filter_DNE,
  output logic [DATA_WIDTH-1:0] Filter_DATA,
  output logic                  Filter_BUSY
);

  localparam int CH_W  = DATA_WIDTH / CHANNELS;
  localparam int N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int CNT_W = $clog2(N + 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] win_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_DONE, S_REARM} state_t;

  state_t             state, state_nxt;
  win_t               win;
  logic [CNT_W-1:0]   cnt;

`ifdef FILTER_MEAN_EN
  localparam int SUM_W = CH_W + $clog2(N);

  // Mean replaces the sort; result lands in the centre slot so DONE is shared.
  function automatic logic [DATA_WIDTH-1:0] window_mean(input win_t w);
    logic [DATA_WIDTH-1:0] r;
    logic [SUM_W-1:0]      sum;
    r = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sum = '0;
      for (int i = 0; i < N; i++)
        sum = sum + SUM_W'(w[i][ch*CH_W +: CH_W]);
      r[ch*CH_W +: CH_W] = CH_W'(sum / SUM_W'(N));
    end
    return r;
  endfunction
`else
  logic [CNT_W-1:0]   pass;

  // One odd-even transposition pass; pairs are disjoint so all swaps read the old window.
  function automatic win_t sort_pass(input win_t w, input logic odd);
    win_t            r;
    logic [CH_W-1:0] a, b;
    r = w;
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == odd) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          a = w[i][ch*CH_W +: CH_W];
          b = w[i+1][ch*CH_W +: CH_W];
          if (a > b) begin
            r[i][ch*CH_W +: CH_W]   = b;
            r[i+1][ch*CH_W +: CH_W] = a;
          end
        end
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Filter_EN) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!Filter_EN)                   state_nxt = S_IDLE;
        else if (cnt == CNT_W'(N - 1))    state_nxt = S_SORT;
      end
`ifdef FILTER_MEAN_EN
      S_SORT:  state_nxt = S_DONE;
`else
      S_SORT:  if (pass == CNT_W'(N - 1)) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_REARM;
      // A still-high enable must not start a new capture.
      S_REARM: if (!Filter_EN) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Control_CLK or posedge Control_RST) begin
    if (Control_RST) begin
      win         <= '0;
      cnt         <= '0;
`ifndef FILTER_MEAN_EN
      pass        <= '0;
`endif
      Filter_DATA <= '0;
      Filter_DNE  <= 1'b0;
    end else begin
      Filter_DNE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Filter_EN) begin
            win[0] <= Filter_PIXEL;
            cnt    <= CNT_W'(1);
          end
        end
        S_LOAD: begin
          if (!Filter_EN) begin
            cnt <= '0;
          end else begin
            win[cnt] <= Filter_PIXEL;
            if (cnt == CNT_W'(N - 1)) begin
              cnt  <= '0;
`ifndef FILTER_MEAN_EN
              pass <= '0;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_SORT: begin
`ifdef FILTER_MEAN_EN
          win[N/2] <= window_mean(win);
`else
          win  <= sort_pass(win, pass[0]);
          pass <= pass + CNT_W'(1);
`endif
        end
        S_DONE: begin
          Filter_DATA <= win[N/2];
          Filter_DNE  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Filter_BUSY = (state == S_LOAD) || (state == S_SORT) || (state == S_DONE);

endmodule

// File: tb/tb_window_median_filter.sv
// Self-checking bench for window_median_filter: random windows against a sort/average model.
module tb_window_median_filter;

`ifdef FILTER_MEAN_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 18;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] pixel;
  logic        dne;
  logic [23:0] data;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] pix [9];
  logic [23:0] exp_data;

  window_median_filter #(.DATA_WIDTH(24), .CHANNELS(3), .WINDOW_SIZE(3)) dut (
    .Control_CLK (clk),
    .Control_RST (rst),
    .Filter_EN   (en),
    .Filter_PIXEL(pixel),
    .Filter_DNE  (dne),
    .Filter_DATA (data),
    .Filter_BUSY (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] ref_filter();
    logic [23:0] r;
    int          q[$];
    int          s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      q.delete();
      s = 0;
      for (int i = 0; i < 9; i++) begin
        q.push_back(int'(pix[i][ch*8 +: 8]));
        s += int'(pix[i][ch*8 +: 8]);
      end
      q.sort();
`ifdef FILTER_MEAN_EN
      r[ch*8 +: 8] = 8'(s / 9);
`else
      r[ch*8 +: 8] = 8'(q[4]);
`endif
    end
    return r;
  endfunction

  task automatic run_window(input logic [23:0] exp, input int hold, input string tag);
    int c;
    bit seen;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en    = 1'b1;
      pixel = pix[i];
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b1 || dne !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_load: busy=%b dne=%b, required busy=1 dne=0", tag, busy, dne);
    end
    seen = 0;
    for (c = 9; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dne === 1'b1) begin
        seen = 1;
        break;
      end
    end
    n_tests++;
    if (!seen || c != LAT) begin
      n_fail++;
      $display("FAIL %s dne_latency: seen=%0d edge=%0d, required edge=%0d", tag, seen, c, LAT);
    end
    n_tests++;
    if (data !== exp) begin
      n_fail++;
      $display("FAIL %s data: got %h, required %h", tag, data, exp);
    end
    exp_data = exp;
    @(posedge clk); #1;
    n_tests++;
    if (dne !== 1'b0) begin
      n_fail++;
      $display("FAIL %s dne_width: dne=%b one edge later, required 0", tag, dne);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dne !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s rearm_hold: dne=%b busy=%b at hold %0d, required 0 0", tag, dne, busy, h);
      end
    end
    @(negedge clk);
    en    = 1'b0;
    pixel = 24'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (dne !== 1'b0) begin n_fail++; $display("FAIL reset_dne: got %b, required 0", dne); end
    n_tests++;
    if (data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 000000", data); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
  endtask

  task automatic test_fixed();
    logic [7:0] c0 [9];
    c0 = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    for (int i = 0; i < 9; i++) pix[i] = {8'(i), 8'hFF, c0[i]};
    run_window(24'h04FF05, 0, "fixed");
    for (int i = 0; i < 9; i++) pix[i] = 24'hFFFFFF;
    run_window(24'hFFFFFF, 0, "all_max");
    for (int i = 0; i < 9; i++) pix[i] = {16'h0, 8'(i + 1)};
    run_window(24'h000005, 0, "ramp");
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < 9; i++)
        pix[i] = (w % 2 == 1) ? {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)}
                              : 24'($urandom);
      run_window(ref_filter(), 0, $sformatf("random%0d", w));
    end
  endtask

  task automatic test_abort();
    int dne_seen;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en    = 1'b1;
      pixel = 24'($urandom);
    end
    @(negedge clk);
    en = 1'b0;
    dne_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (dne === 1'b1) dne_seen++;
    end
    n_tests++;
    if (dne_seen != 0) begin n_fail++; $display("FAIL abort_dne: %0d pulses, required 0", dne_seen); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
    n_tests++;
    if (data !== exp_data) begin n_fail++; $display("FAIL abort_data: got %h, required %h", data, exp_data); end
    for (int i = 0; i < 9; i++) pix[i] = 24'($urandom);
    run_window(ref_filter(), 0, "after_abort");
  endtask

  task automatic test_rearm();
    for (int i = 0; i < 9; i++) pix[i] = 24'($urandom);
    run_window(ref_filter(), 5, "rearm_hold");
    for (int i = 0; i < 9; i++) pix[i] = 24'($urandom);
    run_window(ref_filter(), 0, "rearm_next");
  endtask

  task automatic test_midsort_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en    = 1'b1;
      pixel = 24'($urandom);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (dne !== 1'b0 || data !== 24'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midsort_reset: dne=%b data=%h busy=%b, required 0 000000 0", dne, data, busy);
    end
    exp_data = '0;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) pix[i] = 24'($urandom);
    run_window(ref_filter(), 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_abort();
    test_rearm();
    test_midsort_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
